// File: rtl/sdram_arbit_pkg.sv
// sdram_arbit_pkg: shared SDRAM command/state encodings and idle bus constants
package sdram_arbit_pkg;

    localparam logic [3:0] CMD_NOP      = 4'b0111;
    localparam logic [3:0] CMD_ACTIVE   = 4'b0011;
    localparam logic [3:0] CMD_WRITE    = 4'b0100;
    localparam logic [3:0] CMD_READ     = 4'b0101;
    localparam logic [3:0] CMD_B_STOP   = 4'b0110;
    localparam logic [3:0] CMD_P_CHARGE = 4'b0010;
    localparam logic [3:0] CMD_A_REF    = 4'b0001;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ARBIT = 3'd1;
    localparam logic [2:0] ST_AREF  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_READ  = 3'd4;

    localparam logic [1:0]  DEF_IDLE_BA   = 2'b11;
    localparam logic [12:0] DEF_IDLE_ADDR = 13'h1fff;

    typedef struct packed {
        logic [3:0]  cmd;
        logic [1:0]  ba;
        logic [12:0] addr;
    } sdram_bus_t;

endpackage

// File: rtl/sdram_arbit_if.sv
// sdram_arbit_if: engine-side request/bus signals and SDRAM control pins of the arbiter
interface sdram_arbit_if;

    logic        init_end;
    logic [3:0]  init_cmd;
    logic [1:0]  init_ba;
    logic [12:0] init_addr;
    logic        aref_req;
    logic        aref_end;
    logic [3:0]  aref_cmd;
    logic [1:0]  aref_ba;
    logic [12:0] aref_addr;
    logic        wr_req;
    logic        wr_end;
    logic [3:0]  wr_cmd;
    logic [1:0]  wr_ba;
    logic [12:0] wr_addr;
    logic        wr_sdram_en;
    logic [15:0] wr_data;
    logic        rd_req;
    logic        rd_end;
    logic [3:0]  rd_cmd;
    logic [1:0]  rd_ba;
    logic [12:0] rd_addr;
    logic        aref_en;
    logic        wr_en;
    logic        rd_en;
    logic        sdram_cke;
    logic        sdram_cs_n;
    logic        sdram_ras_n;
    logic        sdram_cas_n;
    logic        sdram_we_n;
    logic [1:0]  sdram_ba;
    logic [12:0] sdram_addr;
    logic [15:0] rd_data;

    modport slave (
        input  init_end, init_cmd, init_ba, init_addr,
        input  aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        input  wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_data,
        input  rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        output aref_en, wr_en, rd_en,
        output sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        output sdram_ba, sdram_addr, rd_data
    );

    modport master (
        output init_end, init_cmd, init_ba, init_addr,
        output aref_req, aref_end, aref_cmd, aref_ba, aref_addr,
        output wr_req, wr_end, wr_cmd, wr_ba, wr_addr, wr_sdram_en, wr_data,
        output rd_req, rd_end, rd_cmd, rd_ba, rd_addr,
        input  aref_en, wr_en, rd_en,
        input  sdram_cke, sdram_cs_n, sdram_ras_n, sdram_cas_n, sdram_we_n,
        input  sdram_ba, sdram_addr, rd_data
    );

endinterface

// File: rtl/sdram_arbit_cmd_mux.sv
// sdram_arbit_cmd_mux: combinational state-to-pin mux and DQ output-enable for the arbiter
module sdram_arbit_cmd_mux
    import sdram_arbit_pkg::*;
#(
    parameter logic [1:0]  IDLE_BA   = DEF_IDLE_BA,
    parameter logic [12:0] IDLE_ADDR = DEF_IDLE_ADDR
) (
    input  logic [2:0]  i_state,
    input  sdram_bus_t  i_init,
    input  sdram_bus_t  i_aref,
    input  sdram_bus_t  i_wr,
    input  sdram_bus_t  i_rd,
    input  logic        i_wr_sdram_en,
    input  logic [15:0] i_wr_data,
    output sdram_bus_t  o_pins,
    output logic        o_dq_oe,
    output logic [15:0] o_dq_out
);

    // Owner's bus goes to the pins; ARBIT and unused codes park the chip on NOP
    always_comb begin
        o_pins   = i_state == ST_IDLE  ? i_init :
                   i_state == ST_AREF  ? i_aref :
                   i_state == ST_WRITE ? i_wr   :
                   i_state == ST_READ  ? i_rd   :
                   sdram_bus_t'({CMD_NOP, IDLE_BA, IDLE_ADDR});
        o_dq_oe  = i_state == ST_WRITE && i_wr_sdram_en;
        o_dq_out = i_wr_data;
    end

endmodule

// File: rtl/sdram_arbit.sv
// sdram_arbit: SDRAM bus arbiter for init/refresh/write/read engines
// Optional SDRAM_ARBIT_RR_EN: round-robin between write and read (refresh stays top priority)
module sdram_arbit
    import sdram_arbit_pkg::*;
#(
    parameter logic [1:0]  IDLE_BA   = DEF_IDLE_BA,
    parameter logic [12:0] IDLE_ADDR = DEF_IDLE_ADDR
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    sdram_arbit_if.slave  bus,
    inout  wire [15:0]    sdram_dq
);

    logic [2:0]  r_state;
    logic [2:0]  w_next;
    logic        w_pick_wr;
    logic        r_aref_en;
    logic        r_wr_en;
    logic        r_rd_en;
    sdram_bus_t  w_pins;
    logic        w_dq_oe;
    logic [15:0] w_dq_out;

`ifdef SDRAM_ARBIT_RR_EN
    logic r_last_wr;

    // Write wins unless read is also waiting and write was served last
    always_comb begin
        w_pick_wr = bus.wr_req && !(bus.rd_req && r_last_wr);
    end

    // Remember which of write/read was granted most recently
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n)
            r_last_wr <= 1'b0;
        else if (r_state == ST_ARBIT && w_next == ST_WRITE)
            r_last_wr <= 1'b1;
        else if (r_state == ST_ARBIT && w_next == ST_READ)
            r_last_wr <= 1'b0;
    end
`else
    // Fixed priority: write always beats read
    always_comb begin
        w_pick_wr = bus.wr_req;
    end
`endif

    // Next-state: arbitrate only in ARBIT, owners return on their own end pulse
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:  if (bus.init_end) w_next = ST_ARBIT;
            ST_ARBIT: w_next = bus.aref_req ? ST_AREF  :
                               w_pick_wr    ? ST_WRITE :
                               bus.rd_req   ? ST_READ  : ST_ARBIT;
            ST_AREF:  if (bus.aref_end) w_next = ST_ARBIT;
            ST_WRITE: if (bus.wr_end)   w_next = ST_ARBIT;
            ST_READ:  if (bus.rd_end)   w_next = ST_ARBIT;
            default:  w_next = ST_IDLE;
        endcase
    end

    // State register and grants; a grant mirrors the state being entered
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_state   <= ST_IDLE;
            r_aref_en <= 1'b0;
            r_wr_en   <= 1'b0;
            r_rd_en   <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_aref_en <= w_next == ST_AREF;
            r_wr_en   <= w_next == ST_WRITE;
            r_rd_en   <= w_next == ST_READ;
        end
    end

    sdram_arbit_cmd_mux #(
        .IDLE_BA   (IDLE_BA),
        .IDLE_ADDR (IDLE_ADDR)
    ) u_cmd_mux (
        .i_state       (r_state),
        .i_init        ({bus.init_cmd, bus.init_ba, bus.init_addr}),
        .i_aref        ({bus.aref_cmd, bus.aref_ba, bus.aref_addr}),
        .i_wr          ({bus.wr_cmd, bus.wr_ba, bus.wr_addr}),
        .i_rd          ({bus.rd_cmd, bus.rd_ba, bus.rd_addr}),
        .i_wr_sdram_en (bus.wr_sdram_en),
        .i_wr_data     (bus.wr_data),
        .o_pins        (w_pins),
        .o_dq_oe       (w_dq_oe),
        .o_dq_out      (w_dq_out)
    );

    assign bus.aref_en     = r_aref_en;
    assign bus.wr_en       = r_wr_en;
    assign bus.rd_en       = r_rd_en;
    assign bus.sdram_cke   = 1'b1;
    assign bus.sdram_cs_n  = w_pins.cmd[3];
    assign bus.sdram_ras_n = w_pins.cmd[2];
    assign bus.sdram_cas_n = w_pins.cmd[1];
    assign bus.sdram_we_n  = w_pins.cmd[0];
    assign bus.sdram_ba    = w_pins.ba;
    assign bus.sdram_addr  = w_pins.addr;
    assign sdram_dq        = w_dq_oe ? w_dq_out : 16'bz;
    assign bus.rd_data     = sdram_dq;

endmodule

// File: tb/tb_sdram_arbit.sv
// tb_sdram_arbit: table-driven vectors plus hand sequences for the SDRAM arbiter
module tb_sdram_arbit;

    localparam logic [18:0] P_INIT = {4'b0010, 2'b00, 13'h0000};
    localparam logic [18:0] P_NOP  = {4'b0111, 2'b11, 13'h1fff};
    localparam logic [18:0] P_AREF = {4'b0001, 2'b10, 13'h0400};
    localparam logic [18:0] P_WR   = {4'b0011, 2'b01, 13'h0123};
    localparam logic [18:0] P_RD   = {4'b0101, 2'b10, 13'h0abc};

    typedef struct packed {
        logic [6:0]  in;
        logic [2:0]  gnt;
        logic [18:0] pins;
    } vec_t;

    logic        sys_clk = 1'b0;
    logic        sys_rst_n = 1'b0;
    logic        tb_dq_en = 1'b0;
    logic [15:0] tb_dq = 16'h0000;
    wire  [15:0] sdram_dq;
    int          n_pass = 0;
    int          n_total = 0;
    vec_t        vecs [12];
    logic [2:0]  rr_exp [3];

    sdram_arbit_if u_if ();

    sdram_arbit u_dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (u_if),
        .sdram_dq  (sdram_dq)
    );

    assign sdram_dq = tb_dq_en ? tb_dq : 16'bz;

    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic chk_bus(input string name, input logic [2:0] gnt, input logic [18:0] pins);
        chk(name, {10'd0, u_if.aref_en, u_if.wr_en, u_if.rd_en,
                   u_if.sdram_cs_n, u_if.sdram_ras_n, u_if.sdram_cas_n, u_if.sdram_we_n,
                   u_if.sdram_ba, u_if.sdram_addr},
            {10'd0, gnt, pins});
    endtask

    task automatic drive(input logic [6:0] v);
        {u_if.init_end, u_if.aref_req, u_if.aref_end, u_if.wr_req,
         u_if.wr_end, u_if.rd_req, u_if.rd_end} = v;
    endtask

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    initial begin
        // inputs: {init_end, aref_req, aref_end, wr_req, wr_end, rd_req, rd_end}
        vecs[0]  = '{7'b0000000, 3'b000, P_INIT};
        vecs[1]  = '{7'b1000000, 3'b000, P_NOP};
        vecs[2]  = '{7'b0001000, 3'b010, P_WR};
        vecs[3]  = '{7'b0101010, 3'b010, P_WR};
        vecs[4]  = '{7'b0010001, 3'b010, P_WR};
        vecs[5]  = '{7'b0100100, 3'b000, P_NOP};
        vecs[6]  = '{7'b0101000, 3'b100, P_AREF};
        vecs[7]  = '{7'b0011010, 3'b000, P_NOP};
        vecs[8]  = '{7'b0000010, 3'b001, P_RD};
        vecs[9]  = '{7'b0000001, 3'b000, P_NOP};
        vecs[10] = '{7'b0000000, 3'b000, P_NOP};
        vecs[11] = '{7'b0010100, 3'b000, P_NOP};
`ifdef SDRAM_ARBIT_RR_EN
        rr_exp[0] = 3'b010; rr_exp[1] = 3'b001; rr_exp[2] = 3'b010;
`else
        rr_exp[0] = 3'b010; rr_exp[1] = 3'b010; rr_exp[2] = 3'b010;
`endif
        drive(7'b0);
        {u_if.init_cmd, u_if.init_ba, u_if.init_addr} = P_INIT;
        {u_if.aref_cmd, u_if.aref_ba, u_if.aref_addr} = P_AREF;
        {u_if.wr_cmd, u_if.wr_ba, u_if.wr_addr}       = P_WR;
        {u_if.rd_cmd, u_if.rd_ba, u_if.rd_addr}       = P_RD;
        u_if.wr_sdram_en = 1'b0;
        u_if.wr_data     = 16'h0000;
        #12;
        chk_bus("reset", 3'b000, P_INIT);
        chk("cke_reset", {31'd0, u_if.sdram_cke}, 32'd1);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge sys_clk);
            drive(vecs[i].in);
            tick();
            chk_bus($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].pins);
        end
        // write data onto DQ, then release it
        @(negedge sys_clk); drive(7'b0001000);
        tick();
        chk_bus("dq_wr_grant", 3'b010, P_WR);
        @(negedge sys_clk); drive(7'b0); u_if.wr_sdram_en = 1'b1; u_if.wr_data = 16'hA5A5;
        #1 chk("dq_write", {16'd0, u_if.rd_data}, 32'h0000A5A5);
        @(negedge sys_clk); u_if.wr_sdram_en = 1'b0; tb_dq_en = 1'b1; tb_dq = 16'h1234;
        #1 chk("dq_wr_off", {16'd0, u_if.rd_data}, 32'h00001234);
        @(negedge sys_clk); tb_dq_en = 1'b0; drive(7'b0000100);
        tick();
        chk_bus("dq_wr_end", 3'b000, P_NOP);
        @(negedge sys_clk); drive(7'b0); u_if.wr_sdram_en = 1'b1; tb_dq_en = 1'b1; tb_dq = 16'h5A5A;
        #1 chk("dq_arbit_z", {16'd0, u_if.rd_data}, 32'h00005A5A);
        @(negedge sys_clk); drive(7'b0000010);
        tick();
        chk_bus("rd_grant", 3'b001, P_RD);
        @(negedge sys_clk); drive(7'b0); tb_dq = 16'h1234;
        #1 chk("read_dq", {16'd0, u_if.rd_data}, 32'h00001234);
        @(negedge sys_clk); tb_dq_en = 1'b0; u_if.wr_sdram_en = 1'b0; drive(7'b0000001);
        tick();
        chk_bus("rd_end", 3'b000, P_NOP);
        // write and read both held: grant pattern depends on arbitration mode
        for (int i = 0; i < 3; i++) begin
            @(negedge sys_clk); drive(7'b0001010);
            tick();
            chk("alt_grant", {29'd0, u_if.aref_en, u_if.wr_en, u_if.rd_en}, {29'd0, rr_exp[i]});
            @(negedge sys_clk); drive(7'b0001111);
            tick();
            chk_bus("alt_gap", 3'b000, P_NOP);
        end
        @(negedge sys_clk); drive(7'b0);
        tick();
        // asynchronous reset in the middle of a write burst
        @(negedge sys_clk); drive(7'b0001000);
        tick();
        chk_bus("mid_wr_grant", 3'b010, P_WR);
        @(negedge sys_clk); drive(7'b0); u_if.wr_sdram_en = 1'b1; u_if.wr_data = 16'hA5A5;
        #2;
        sys_rst_n = 1'b0; tb_dq_en = 1'b1; tb_dq = 16'h1234;
        #1;
        chk_bus("async_reset", 3'b000, P_INIT);
        chk("async_reset_dq", {16'd0, u_if.rd_data}, 32'h00001234);
        @(negedge sys_clk); sys_rst_n = 1'b1; tb_dq_en = 1'b0; u_if.wr_sdram_en = 1'b0;
        tick();
        chk_bus("post_reset_idle", 3'b000, P_INIT);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
